// File: rtl/mem_access_unit.sv
// mem_access_unit: turns byte/half/word load and store requests into
// word-wide accesses on a simple memory port. Sub-word stores use a
// read-modify-write. Each accepted request yields exactly one response.
module mem_access_unit #(
   parameter bit BIG_ENDIAN  = 1'b0,
   parameter bit CHECK_ALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_misaligned,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP} state_t;

   state_t      state_q;
   logic        write_q, signed_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q, merge_q, rdata_q;
   logic        resp_valid_q, misal_q;

   logic        accept;
   logic [1:0]  byte_lane;
   logic        half_lane;
   logic [4:0]  sh_byte, sh_half;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_d, merge_d;
   logic        misal_d;

   // Ready only while idle and out of reset; strobes decode from state only.
   assign req_ready       = rst_n && (state_q == S_IDLE);
   assign accept          = req_valid && req_ready;
   assign mem_read        = (state_q == S_RD) || (state_q == S_RMW_RD);
   assign mem_write       = (state_q == S_WR);
   assign mem_addr        = {addr_q[31:2], 2'b00};
   assign mem_wdata       = (state_q == S_WR) ? (size_q[1] ? wdata_q : merge_q) : 32'h0;
   assign resp_valid      = resp_valid_q;
   assign resp_rdata      = rdata_q;
   assign resp_misaligned = misal_q;

   // Lane selection, load extension, store merge and alignment check.
   always_comb begin
      byte_lane = addr_q[1:0] ^ {2{BIG_ENDIAN}};
      half_lane = addr_q[1] ^ BIG_ENDIAN;
      sh_byte   = {byte_lane, 3'b000};
      sh_half   = {half_lane, 4'b0000};
      rd_byte   = 8'(mem_rdata >> sh_byte);
      rd_half   = 16'(mem_rdata >> sh_half);
      load_d    = mem_rdata;
      merge_d   = wdata_q;
      case (size_q)
         2'b00: begin
            load_d  = {{24{signed_q & rd_byte[7]}}, rd_byte};
            merge_d = (mem_rdata & ~(32'h0000_00FF << sh_byte)) |
                      ({24'h0, wdata_q[7:0]} << sh_byte);
         end
         2'b01: begin
            load_d  = {{16{signed_q & rd_half[15]}}, rd_half};
            merge_d = (mem_rdata & ~(32'h0000_FFFF << sh_half)) |
                      ({16'h0, wdata_q[15:0]} << sh_half);
         end
         default: begin
            load_d  = mem_rdata;
            merge_d = wdata_q;
         end
      endcase
      // With checking off, the masked low bits simply fall out of lane select.
      misal_d = CHECK_ALIGN &&
                (((req_size == 2'b01) && req_addr[0]) ||
                 (req_size[1] && (req_addr[1:0] != 2'b00)));
   end

   // Request FSM: latches fields at accept, sequences memory, emits response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         write_q      <= 1'b0;
         signed_q     <= 1'b0;
         size_q       <= 2'b00;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         merge_q      <= 32'h0;
         rdata_q      <= 32'h0;
         resp_valid_q <= 1'b0;
         misal_q      <= 1'b0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  write_q  <= req_write;
                  signed_q <= req_signed;
                  size_q   <= req_size;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  rdata_q  <= 32'h0;
                  misal_q  <= misal_d;
                  if (misal_d) begin
                     resp_valid_q <= 1'b1;
                     state_q      <= S_RESP;
                  end else if (!req_write) begin
                     state_q <= S_RD;
                  end else if (req_size[1]) begin
                     state_q <= S_WR;
                  end else begin
                     state_q <= S_RMW_RD;
                  end
               end
            end
            S_RD: begin
               rdata_q      <= load_d;
               resp_valid_q <= 1'b1;
               state_q      <= S_RESP;
            end
            S_RMW_RD: begin
               merge_q <= merge_d;
               state_q <= S_WR;
            end
            S_WR: begin
               resp_valid_q <= 1'b1;
               state_q      <= S_RESP;
            end
            S_RESP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the word-addressed data memory interface: mem_read/mem_write, 32-bit address, write data, and combinational read data, with memory committing writes on the falling clock edge.
- Takes byte, halfword and word load/store requests from the CPU datapath, which string printing and character handling need.
- Converts each request into one or two word accesses on the memory side. Sub-word stores use a read-modify-write sequence.
- Handles lane extraction, sign/zero extension and alignment checking, and returns one response per request.

Parameters:
BIG_ENDIAN, 0, 0: byte at addr[1:0]=0 is bits 7:0 (little-endian); 1: byte 0 is bits 31:24.
CHECK_ALIGN, 1, 1: misaligned half/word requests return an error with no memory access; 0: low address bits are masked instead (half uses addr[1], word ignores addr[1:0]).

Ports:
clk  in  1  system clock, rising edge active
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word
req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified for sub-word sizes
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_misaligned  out  1  qualifies resp_valid: alignment error
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe; memory commits on the negedge of the same cycle
mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
mem_wdata  out  32  full word to write
mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE.
  - req_ready=0 (gated by rst_n), resp_valid=0, resp_rdata=0, resp_misaligned=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - Merge register is cleared.
- Handshake:
  - Accept occurs when req_valid && req_ready at a rising edge.
  - req_ready=1 only in IDLE with rst_n high.
  - All request fields are latched at accept. Input changes while busy are ignored.
- FSM states: IDLE, RD, RMW_RD, WR, RESP.
- IDLE on accept:
  - misaligned (CHECK_ALIGN=1; half with addr[0]=1, word with addr[1:0]!=0) -> RESP with misaligned flag.
  - load -> RD.
  - word store -> WR.
  - byte/half store -> RMW_RD.
- RD:
  - mem_read=1, mem_addr=word address.
  - At the rising edge, select the lane from mem_rdata, extend per req_signed, register into resp_rdata, then -> RESP.
- RMW_RD:
  - mem_read=1.
  - At the rising edge, capture mem_rdata, replace the target byte or half lane with req_wdata[7:0] or [15:0], hold the result in the merge register, then -> WR.
- WR:
  - mem_write=1, mem_wdata = merge register (sub-word) or req_wdata (word), mem_addr=word address.
  - -> RESP.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - resp_misaligned is valid this cycle.
  - resp_rdata = load data, else 0.
  - -> IDLE.
- mem_read and mem_write decode from registered state only, are never both 1, and are low in IDLE and RESP.
- Latency from the accept edge to resp_valid high:
  - load: 2 cycles.
  - word store: 2 cycles.
  - sub-word store: 3 cycles.
  - error: 1 cycle.
- Throughput: the next accept can occur at the edge that leaves RESP→IDLE plus one cycle. There is no overlap between requests.
- Lane selection: byte lane = addr[1:0]; half lane = addr[1]. BIG_ENDIAN mirrors the lanes.
- Reset mid-operation:
  - Strobes drop immediately.
  - A store interrupted before the WR negedge does not modify memory.
  - No response is produced for the aborted request.

Test Plan:
- Memory model: behavioural array, combinational read, negedge write, BIG_ENDIAN=0.
- Word store then load: sw 0xDEADBEEF to 0x7FFFFBFC, then lw the same address -> memory word 0xDEADBEEF; lw resp_rdata=0xDEADBEEF; resp_valid 2 cycles after each accept; one mem_write pulse and no mem_read for the sw.
- Byte read-modify-write: over 0xDEADBEEF, sb 0x41 to 0x7FFFFBFD -> mem_read pulse then mem_write pulse with mem_wdata=0xDEAD41EF, resp at 3 cycles. Follow-up loads:
  - lbu 0x7FFFFBFD -> 0x00000041.
  - lb 0x7FFFFBFF -> 0xFFFFFFDE.
  - lbu 0x7FFFFBFF -> 0x000000DE.
- Halfword: sh 0x8001 to 0x7FFFFBFE -> word 0x800141EF. Follow-up loads:
  - lh -> 0xFFFF8001.
  - lhu -> 0x00008001.
  - lhu 0x7FFFFBFC -> 0x000041EF.
- Misaligned: lw 0x7FFFFBFE and sh 0x7FFFFBFD -> resp_valid and resp_misaligned=1 one cycle after accept, resp_rdata=0, zero memory strobes, memory unchanged.
- Reset abort: assert rst_n low during RMW_RD of sb 0xFF -> mem_read falls without waiting for a clock edge, word unchanged, no resp_valid. After release, req_ready=1 and the next lw returns the old value.
- Back-to-back: req_valid held high with 4 queued requests, changing fields while busy -> exactly 4 resp pulses, req_ready low in all non-IDLE cycles, each response matches the fields latched at its own accept.
